alu_processor: RTL and testbench

- Small multi-cycle 16-bit register-to-register ALU processor.
- Fetches 16-bit ALU instructions from port A of a shared dual-port RAM, executes them on an internal 16x16 register bank, and writes every result to the register bank and to port B of the same RAM.
- Used as a standalone processor core, with the RAM and its interface instantiated alongside it at the top level.

---
 rtl/proc_pkg.sv | 34 +++
 rtl/alu_processor_reg_bank.sv | 31 +++
 rtl/alu_processor.sv | 101 ++++++++++
 tb/tb_alu_processor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types for the alu_processor core: opcodes, instruction layout, FSM states.
package proc_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned REG_IDX_W  = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;

  typedef struct packed {
    opcode_t              op;
    logic                 rsv;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
  } instr_t;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

endpackage

// File: rtl/alu_processor_reg_bank.sv
// 16x16 register bank: two asynchronous read ports, one synchronous write port.
module reg_bank
  import proc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_IDX_W-1:0]  raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [REG_IDX_W-1:0]  raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  we,
  input  logic [REG_IDX_W-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_processor.sv
// Multi-cycle register-to-register ALU core: fetch from RAM port A, execute on the
// register bank, store every result to RAM port B at RESULT_BASE + rd.
module alu_processor #(
  parameter int unsigned            DATA_WIDTH  = 16,
  parameter int unsigned            ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESULT_BASE = 'h80
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  output logic [ADDR_WIDTH-1:0] o_a_addr,
  output logic                  o_a_en,
  input  logic [DATA_WIDTH-1:0] i_a_rdata,
  output logic [ADDR_WIDTH-1:0] o_b_addr,
  output logic                  o_b_we,
  output logic [DATA_WIDTH-1:0] o_b_wdata,
  output logic                  o_halted
);

  import proc_pkg::*;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  instr_t                ir;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;
  logic [DATA_WIDTH-1:0] result;
  logic                  wr_en;
  logic                  unused_rsv;

  function automatic logic [DATA_WIDTH-1:0] alu(
    input opcode_t               op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[3:0];
      OP_SHR:  return a >> b[3:0];
      default: return '0;
    endcase
  endfunction

  reg_bank u_bank (
    .clk    (i_clock),
    .rst    (i_reset),
    .raddr1 (ir.rs1),
    .rdata1 (rs1_val),
    .raddr2 (ir.rs2),
    .rdata2 (rs2_val),
    .we     (wr_en),
    .waddr  (ir.rd),
    .wdata  (result)
  );

  assign result     = alu(ir.op, rs1_val, rs2_val);
  assign wr_en      = (state == S_EXEC) && (ir.op != OP_HALT);
  assign unused_rsv = ir.rsv;

  // Fetch request is a pure state decode, held low while reset is asserted.
  assign o_a_en    = (state == S_FETCH) && !i_reset;
  assign o_a_addr  = pc;
  assign o_b_we    = wr_en;
  assign o_b_addr  = RESULT_BASE + ADDR_WIDTH'(ir.rd);
  assign o_b_wdata = result;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      o_halted <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          ir    <= instr_t'(i_a_rdata);
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (ir.op == OP_HALT) begin
            state    <= S_HALTED;
            o_halted <= 1'b1;
          end else begin
            pc    <= pc + ADDR_WIDTH'(1);
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_processor.sv
// Directed bench for alu_processor with a behavioural dual-port RAM alongside the core.
module tb_alu_processor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a_addr;
  logic        a_en;
  logic [15:0] a_rdata = '0;
  logic [7:0]  b_addr;
  logic        b_we;
  logic [15:0] b_wdata;
  logic        halted;

  logic [15:0] mem [256];
  int          edges = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [3:0]  rd;
    logic [7:0]  b_addr;
    logic [15:0] b_data;
  } vec_t;

  vec_t vecs [7];

  alu_processor #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (8),
    .RESULT_BASE (8'h80)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .o_a_addr  (a_addr),
    .o_a_en    (a_en),
    .i_a_rdata (a_rdata),
    .o_b_addr  (b_addr),
    .o_b_we    (b_we),
    .o_b_wdata (b_wdata),
    .o_halted  (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edges <= edges + 1;
    if (a_en) a_rdata <= mem[a_addr];
    if (b_we) mem[b_addr] <= b_wdata;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_we(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b_we) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_main();
    mem[0] <= 16'h0610;
    mem[1] <= 16'hC210;
    mem[2] <= 16'hA210;
    mem[3] <= 16'h8210;
    mem[4] <= 16'h6210;
    mem[5] <= 16'h4210;
    mem[6] <= 16'h2210;
    mem[7] <= 16'hE210;
  endtask

  initial begin
    bit ok;
    bit found;
    int rel;
    int last;
    int activity;

    vecs[0] = '{rd: 4'd6, b_addr: 8'h86, b_data: 16'd40};
    vecs[1] = '{rd: 4'd2, b_addr: 8'h82, b_data: 16'h0000};
    vecs[2] = '{rd: 4'd2, b_addr: 8'h82, b_data: 16'h8000};
    vecs[3] = '{rd: 4'd2, b_addr: 8'h82, b_data: 16'd20};
    vecs[4] = '{rd: 4'd2, b_addr: 8'h82, b_data: 16'd30};
    vecs[5] = '{rd: 4'd2, b_addr: 8'h82, b_data: 16'd10};
    vecs[6] = '{rd: 4'd2, b_addr: 8'h82, b_data: 16'hFFEC};

    // Main program
    rst = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] <= '0;
    repeat (3) @(negedge clk);
    load_main();
    chk("reset_a_en", a_en, 1'b0);
    chk("reset_b_we", b_we, 1'b0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_pc", dut.pc, 8'd0);
    rst = 1'b0;
    dut.u_bank.regs[0] <= 16'd30;
    dut.u_bank.regs[1] <= 16'd10;
    dut.u_bank.regs[2] <= 16'd20;
    rel = edges;
    #1;
    chk("first_fetch_en", a_en, 1'b1);
    chk("first_fetch_addr", a_addr, 8'd0);
    last = 0;
    for (int i = 0; i < 7; i++) begin
      wait_we(ok);
      chk($sformatf("we_timeout_%0d", i), ok, 1'b1);
      chk($sformatf("b_addr_%0d", i), b_addr, vecs[i].b_addr);
      chk($sformatf("b_data_%0d", i), b_wdata, vecs[i].b_data);
      if (i == 0) chk("first_we_edge", edges - rel, 2);
      else chk($sformatf("we_spacing_%0d", i), edges - last, 3);
      last = edges;
      @(negedge clk);
      chk($sformatf("reg_%0d", i), dut.u_bank.regs[vecs[i].rd], vecs[i].b_data);
    end
    wait_halt(ok);
    chk("halt_seen", ok, 1'b1);
    chk("halt_pc", dut.pc, 8'd7);
    activity = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_en || b_we) activity++;
    end
    chk("halted_quiet", activity, 0);
    chk("halted_stays", halted, 1'b1);
    chk("mem_82", mem[8'h82], 16'hFFEC);
    chk("mem_86", mem[8'h86], 16'd40);

    // Reset during DECODE of instruction 3
    rst = 1'b1;
    @(negedge clk);
    load_main();
    rst = 1'b0;
    dut.u_bank.regs[0] <= 16'd30;
    dut.u_bank.regs[1] <= 16'd10;
    dut.u_bank.regs[2] <= 16'd20;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_en && a_addr == 8'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("fetch3_seen", found, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_pc", dut.pc, 8'd0);
    chk("abort_r6", dut.u_bank.regs[6], 16'd0);
    chk("abort_r2", dut.u_bank.regs[2], 16'd0);
    chk("abort_r0", dut.u_bank.regs[0], 16'd0);
    chk("abort_b_we", b_we, 1'b0);
    chk("abort_a_en", a_en, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_no_store", mem[8'h82], 16'h8000);
    rst = 1'b0;
    #1;
    chk("restart_en", a_en, 1'b1);
    chk("restart_addr", a_addr, 8'd0);

    // rd == rs1 == rs2, carry dropped
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem[0] <= 16'h0000;
    mem[1] <= 16'hE000;
    rst = 1'b0;
    dut.u_bank.regs[0] <= 16'h9000;
    wait_we(ok);
    chk("same_we_timeout", ok, 1'b1);
    chk("same_b_addr", b_addr, 8'h80);
    chk("same_b_data", b_wdata, 16'h2000);
    @(negedge clk);
    chk("same_r0", dut.u_bank.regs[0], 16'h2000);
    wait_halt(ok);
    chk("same_halt", ok, 1'b1);
    chk("same_halt_pc", dut.pc, 8'd1);

    // pc wrap from 255 to 0
    rst = 1'b1;
    @(negedge clk);
    mem[255] <= 16'h0110;
    mem[0]   <= 16'hE000;
    rst = 1'b0;
    dut.pc <= 8'd255;
    dut.u_bank.regs[1] <= 16'd5;
    dut.u_bank.regs[0] <= 16'd3;
    #1;
    chk("wrap_fetch_addr", a_addr, 8'd255);
    wait_we(ok);
    chk("wrap_we_timeout", ok, 1'b1);
    chk("wrap_b_addr", b_addr, 8'h81);
    chk("wrap_b_data", b_wdata, 16'd8);
    @(negedge clk);
    chk("wrap_next_en", a_en, 1'b1);
    chk("wrap_next_addr", a_addr, 8'd0);
    wait_halt(ok);
    chk("wrap_halt", ok, 1'b1);
    chk("wrap_halt_pc", dut.pc, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
